// File: rtl/rename_free_list_ctrl_pkg.sv
// Shared types for the rename-stage free-list controller.
// Defines the architectural/physical register widths, the alias-map type
// exchanged with the register alias table, the controller state encoding
// and a helper that tests a physical register against a map.
package rename_pkg;

    localparam int unsigned NUM_ARCH = 32;
    localparam int unsigned NUM_PHYS = 64;
    localparam int unsigned ARCH_W   = 5;
    localparam int unsigned PHYS_W   = 6;
    localparam int unsigned CNT_W    = 7;

    typedef logic [ARCH_W-1:0] arch_t;
    typedef logic [PHYS_W-1:0] phys_t;
    typedef logic [CNT_W-1:0]  count_t;
    typedef phys_t             map_t [NUM_ARCH];

    typedef enum logic {
        RUN,
        RECOVER
    } state_t;

    // True when any architectural entry of the map points at phys p.
    function automatic logic phys_in_map(phys_t p, map_t m);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < NUM_ARCH; i++) begin
            hit = hit | (m[i] == p);
        end
        return hit;
    endfunction

endpackage

// File: rtl/rename_free_list_ctrl_if.sv
// Rename/commit/flush handshake and alias-table control bus.
// master: pipeline side (drives requests, commit frees, flush, committed map).
// slave : free-list controller (drives ready, allocation and table writes).
interface rename_free_list_ctrl_if;
    import rename_pkg::*;

    logic  rename_valid;
    logic  rename_writes;
    arch_t rename_dest_reg;
    logic  rename_ready;
    phys_t alloc_phys;

    arch_t reg_to_map;
    phys_t new_mapping;
    logic  remap;

    logic  commit_valid;
    phys_t commit_free_phys;

    logic  flush;
    map_t  committed_map;
    map_t  new_map;
    logic  overwrite;

    modport master (
        output rename_valid, rename_writes, rename_dest_reg,
        input  rename_ready, alloc_phys,
        input  reg_to_map, new_mapping, remap,
        output commit_valid, commit_free_phys,
        output flush, committed_map,
        input  new_map, overwrite
    );

    modport slave (
        input  rename_valid, rename_writes, rename_dest_reg,
        output rename_ready, alloc_phys,
        output reg_to_map, new_mapping, remap,
        input  commit_valid, commit_free_phys,
        input  flush, committed_map,
        output new_map, overwrite
    );

endinterface

// File: rtl/rename_free_list_ctrl_free_list_fifo.sv
// Circular free list of physical register numbers.
// Ports: clk/reset; clear empties the list; push/push_data append at tail;
// pop removes the head entry, whose value is always visible on pop_data;
// count/empty/full report occupancy; overflow_err is sticky until reset and
// records a push attempted while full (the pushed entry is dropped).
module free_list_fifo
    import rename_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   clear,
    input  logic   push,
    input  phys_t  push_data,
    input  logic   pop,
    output phys_t  pop_data,
    output count_t count,
    output logic   empty,
    output logic   full,
    output logic   overflow_err
);

    phys_t  mem [NUM_PHYS];
    phys_t  head;
    phys_t  tail;
    count_t cnt;
    logic   ovf;
    logic   push_ok;
    logic   pop_ok;

    assign empty        = (cnt == '0);
    assign full         = (cnt == count_t'(NUM_PHYS));
    assign count        = cnt;
    assign pop_data     = mem[head];
    assign overflow_err = ovf;
    assign push_ok      = push & ~full;
    assign pop_ok       = pop & ~empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Upper half of the phys space is free, matching an identity
            // alias table (arch i -> phys i) out of reset.
            for (int unsigned i = 0; i < NUM_PHYS; i++) begin
                mem[i] <= (i < NUM_ARCH) ? phys_t'(i + NUM_ARCH) : '0;
            end
            head <= '0;
            tail <= phys_t'(NUM_ARCH);
            cnt  <= count_t'(NUM_ARCH);
            ovf  <= 1'b0;
        end else begin
            if (push && full) begin
                ovf <= 1'b1;
            end
            if (clear) begin
                head <= '0;
                tail <= '0;
                cnt  <= '0;
            end else begin
                if (push_ok) begin
                    mem[tail] <= push_data;
                    tail      <= tail + phys_t'(1);
                end
                if (pop_ok) begin
                    head <= head + phys_t'(1);
                end
                cnt <= cnt + count_t'(push_ok) - count_t'(pop_ok);
            end
        end
    end

endmodule

// File: rtl/rename_free_list_ctrl.sv
// Rename-stage controller: allocates physical registers from the free list
// for renamed destinations, drives the alias table's single-entry remap and
// whole-map overwrite ports, returns registers at commit, and rebuilds the
// free list after a flush by walking all phys registers against a snapshot
// of the committed map.
// Ports: clk, reset (sync, active high); bus (slave side of the rename/
// commit/flush/table interface); recovering (high in RECOVER);
// free_count (current list occupancy); overflow_err (sticky push-when-full).
module rename_free_list_ctrl
    import rename_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    rename_free_list_ctrl_if.slave bus,
    output logic                   recovering,
    output count_t                 free_count,
    output logic                   overflow_err
);

    state_t state, state_next;
    phys_t  walk_p;
    map_t   snap;

    logic   fl_clear;
    logic   fl_push;
    phys_t  fl_push_data;
    logic   fl_pop;
    phys_t  fl_pop_data;
    logic   fl_empty;
    logic   fl_full;

    free_list_fifo u_free_list (
        .clk          (clk),
        .reset        (reset),
        .clear        (fl_clear),
        .push         (fl_push),
        .push_data    (fl_push_data),
        .pop          (fl_pop),
        .pop_data     (fl_pop_data),
        .count        (free_count),
        .empty        (fl_empty),
        .full         (fl_full),
        .overflow_err (overflow_err)
    );

    assign recovering      = (state == RECOVER);
    assign bus.alloc_phys  = fl_pop_data;
    assign bus.new_mapping = fl_pop_data;
    assign bus.reg_to_map  = bus.rename_dest_reg;
    assign bus.overwrite   = bus.flush;
    assign bus.new_map     = bus.committed_map;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= RUN;
            walk_p <= '0;
            snap   <= '{default: '0};
        end else begin
            state <= state_next;
            if (bus.flush) begin
                snap   <= bus.committed_map;
                walk_p <= '0;
            end else if (state == RECOVER) begin
                walk_p <= walk_p + phys_t'(1);
            end
        end
    end

    always_comb begin
        state_next       = state;
        bus.rename_ready = 1'b0;
        bus.remap        = 1'b0;
        fl_clear         = 1'b0;
        fl_push          = 1'b0;
        fl_push_data     = bus.commit_free_phys;
        fl_pop           = 1'b0;

        if (bus.flush) begin
            // Flush wins over same-cycle rename and commit in either state.
            fl_clear   = 1'b1;
            state_next = RECOVER;
        end else begin
            unique case (state)
                RUN: begin
                    bus.rename_ready = ~fl_empty | ~bus.rename_writes;
                    if (bus.rename_valid && bus.rename_writes && !fl_empty) begin
                        bus.remap = 1'b1;
                        fl_pop    = 1'b1;
                    end
                    fl_push = bus.commit_valid;
                end
                RECOVER: begin
                    // Commits are ignored: the snapshot already covers them.
                    if (!phys_in_map(walk_p, snap)) begin
                        fl_push      = 1'b1;
                        fl_push_data = walk_p;
                    end
                    if (walk_p == phys_t'(NUM_PHYS - 1)) begin
                        state_next = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    logic unused_full;
    assign unused_full = fl_full;

endmodule

// File: tb/tb_rename_free_list_ctrl.sv
module tb_rename_free_list_ctrl;
    import rename_pkg::*;

    logic   clk;
    logic   reset;
    logic   recovering;
    count_t free_count;
    logic   overflow_err;

    rename_free_list_ctrl_if bus ();

    rename_free_list_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .recovering   (recovering),
        .free_count   (free_count),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Reference model: free list as a queue, recovery as a counted walk.
    phys_t mq[$];
    bit    m_ovf;
    bit    m_rec;
    int    m_p;
    bit    m_used [NUM_PHYS];
    map_t  cmap;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 32; i++) mq.push_back(phys_t'(i + 32));
        m_ovf = 1'b0;
        m_rec = 1'b0;
        m_p   = 0;
    endtask

    task automatic do_reset();
        bus.rename_valid = 1'b0;
        bus.rename_writes = 1'b0;
        bus.rename_dest_reg = '0;
        bus.commit_valid = 1'b0;
        bus.commit_free_phys = '0;
        bus.flush = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic step(bit v, bit w, arch_t d, bit cv, phys_t cf, bit fl);
        bit exp_ready;
        bit exp_remap;
        bit full_before;
        bus.rename_valid     = v;
        bus.rename_writes    = w;
        bus.rename_dest_reg  = d;
        bus.commit_valid     = cv;
        bus.commit_free_phys = cf;
        bus.flush            = fl;
        bus.committed_map    = cmap;
        @(negedge clk);
        exp_ready = !fl && !m_rec && (mq.size() != 0 || !w);
        exp_remap = v && w && exp_ready;
        check_eq("rename_ready", 32'(bus.rename_ready), 32'(exp_ready));
        check_eq("remap", 32'(bus.remap), 32'(exp_remap));
        if (exp_remap) begin
            check_eq("alloc_phys", 32'(bus.alloc_phys), 32'(mq[0]));
            check_eq("new_mapping", 32'(bus.new_mapping), 32'(mq[0]));
            check_eq("reg_to_map", 32'(bus.reg_to_map), 32'(d));
        end
        check_eq("overwrite", 32'(bus.overwrite), 32'(fl));
        if (fl) begin
            for (int i = 0; i < NUM_ARCH; i++)
                check_eq("new_map", 32'(bus.new_map[i]), 32'(cmap[i]));
        end
        check_eq("recovering", 32'(recovering), 32'(m_rec));
        check_eq("free_count", 32'(free_count), 32'(mq.size()));
        check_eq("overflow_err", 32'(overflow_err), 32'(m_ovf));
        @(posedge clk);
        if (fl) begin
            mq.delete();
            for (int i = 0; i < NUM_PHYS; i++) m_used[i] = 1'b0;
            for (int i = 0; i < NUM_ARCH; i++) m_used[cmap[i]] = 1'b1;
            m_rec = 1'b1;
            m_p   = 0;
        end else if (m_rec) begin
            if (!m_used[m_p]) mq.push_back(phys_t'(m_p));
            m_p++;
            if (m_p == NUM_PHYS) m_rec = 1'b0;
        end else begin
            full_before = (mq.size() == NUM_PHYS);
            if (exp_remap) void'(mq.pop_front());
            if (cv) begin
                if (full_before) m_ovf = 1'b1;
                else mq.push_back(cf);
            end
        end
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0, 0);
    endtask

    task automatic rand_map();
        int perm [NUM_PHYS];
        int j, t;
        for (int i = 0; i < NUM_PHYS; i++) perm[i] = i;
        for (int i = NUM_PHYS - 1; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int i = 0; i < NUM_ARCH; i++) cmap[i] = phys_t'(perm[i]);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < NUM_ARCH; i++) cmap[i] = phys_t'(i);
        do_reset();

        // Reset state, then four writing renames to arch 3..6.
        idle(1);
        for (int i = 3; i <= 6; i++) step(1, 1, arch_t'(i), 0, '0, 0);
        check_eq("free_count_after4", 32'(free_count), 32'd28);

        // Drain the list; stall on empty; non-writing still accepted.
        for (int i = 0; i < 28; i++) step(1, 1, arch_t'(i), 0, '0, 0);
        step(1, 1, arch_t'(9), 0, '0, 0);
        step(1, 0, arch_t'(9), 0, '0, 0);
        step(1, 1, arch_t'(9), 1, phys_t'(7), 0);   // no bypass at count 0
        step(1, 1, arch_t'(9), 0, '0, 0);           // allocates 7

        // Fill to 10, then rename and commit together.
        for (int i = 10; i < 20; i++) step(0, 0, '0, 1, phys_t'(i), 0);
        step(1, 1, arch_t'(1), 1, phys_t'(2), 0);
        check_eq("free_count_same_cycle", 32'(free_count), 32'd10);
        for (int i = 0; i < 10; i++) step(1, 1, arch_t'(i), 0, '0, 0);

        // Flush with committed_map[i] = i+32; full 64-cycle walk.
        for (int i = 0; i < NUM_ARCH; i++) cmap[i] = phys_t'(i + 32);
        step(1, 1, arch_t'(1), 1, phys_t'(5), 1);
        for (int i = 0; i < 64; i++) step(1, 1, arch_t'(2), 1, phys_t'(5), 0);
        check_eq("free_count_after_walk", 32'(free_count), 32'd32);
        step(1, 1, arch_t'(2), 0, '0, 0);

        // Flush, re-flush at walk cycle 20, then reset mid-recovery.
        rand_map();
        step(0, 0, '0, 0, '0, 1);
        idle(19);
        rand_map();
        step(1, 1, arch_t'(4), 0, '0, 1);
        idle(10);
        do_reset();
        check_eq("free_count_reset_mid_rec", 32'(free_count), 32'd32);
        step(1, 1, arch_t'(8), 0, '0, 0);

        // Overflow from the reset state.
        do_reset();
        for (int i = 0; i < 33; i++) step(0, 0, '0, 1, phys_t'(i), 0);
        check_eq("overflow_set", 32'(overflow_err), 32'd1);
        idle(2);
        do_reset();
        idle(1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            bit fl;
            fl = ($urandom_range(0, 79) == 0);
            if (fl) rand_map();
            step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0),
                 arch_t'($urandom), bit'($urandom_range(0, 2) == 0),
                 phys_t'($urandom), fl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
